// File: rtl/mipi_dsi_pkg.sv
// Shared definitions for the MIPI lane alignment controller: FSM encoding and default sizing.
// Pure declarations; no latency or flow control involved.
package mipi_dsi_pkg;

    localparam int DEF_LANES        = 2;
    localparam int DEF_SKEW_TIMEOUT = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_ALIGNED   = 2'd2,
        ST_ERROR     = 2'd3
    } align_state_e;

endpackage

// File: rtl/mipi_skew_timer.sv
// Inter-lane skew timer: counts byte_clk cycles since the first lane sync; expired is combinational from the count.
// Loads 1 on start, holds at SKEW_TIMEOUT (never wraps); no backpressure.
module mipi_skew_timer
    import mipi_dsi_pkg::*;
#(
    parameter int SKEW_TIMEOUT = DEF_SKEW_TIMEOUT
) (
    input  logic byte_clk,
    input  logic sys_rst_n,
    input  logic clear,
    input  logic start,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(SKEW_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(SKEW_TIMEOUT);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0] cnt;

    always_ff @(posedge byte_clk) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= ONE;
        end else if (enable && (cnt != LIMIT)) begin
            cnt <= cnt + ONE;
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/mipi_lane_align_ctrl.sv
// Sequences HS lane sync into the multi-lane aligner; state and flags update one byte_clk after inputs, valid gating is combinational.
// No backpressure. Define MIPI_ALIGN_ERR_CNT_EN to build the saturating err_cnt counter (tied to 0 otherwise).
module mipi_lane_align_ctrl
    import mipi_dsi_pkg::*;
#(
    parameter int LANES        = DEF_LANES,
    parameter int SKEW_TIMEOUT = DEF_SKEW_TIMEOUT
) (
    input  logic             byte_clk,
    input  logic             sys_rst_n,
    input  logic [LANES-1:0] lane_hs_active,
    input  logic [LANES-1:0] lane_sync_det,
    input  logic [LANES-1:0] lanes_data_in_valid,
    input  logic             aligner_error,
    output logic [LANES-1:0] lanes_valid_gated,
    output logic             align_rst_n,
    output logic             align_done,
    output logic             skew_err,
    output logic [7:0]       err_cnt,
    output logic [1:0]       state_dbg
);

    align_state_e     state, state_nxt;
    logic [LANES-1:0] seen, seen_nxt, seen_upd;
    logic             skew_err_nxt;
    logic             tmr_clr, tmr_start, tmr_en, tmr_expired;

    mipi_skew_timer #(
        .SKEW_TIMEOUT (SKEW_TIMEOUT)
    ) u_skew_timer (
        .byte_clk  (byte_clk),
        .sys_rst_n (sys_rst_n),
        .clear     (tmr_clr),
        .start     (tmr_start),
        .enable    (tmr_en),
        .expired   (tmr_expired)
    );

    assign seen_upd = seen | lane_sync_det;

    always_comb begin
        state_nxt    = state;
        seen_nxt     = seen;
        skew_err_nxt = 1'b0;
        tmr_clr      = 1'b0;
        tmr_start    = 1'b0;
        tmr_en       = 1'b0;
        case (state)
            ST_IDLE: begin
                seen_nxt = '0;
                tmr_clr  = 1'b1;
                if (|lane_sync_det) begin
                    seen_nxt = lane_sync_det;
                    if (&lane_sync_det) begin
                        state_nxt = ST_ALIGNED;
                    end else begin
                        state_nxt = ST_WAIT_SYNC;
                        tmr_clr   = 1'b0;
                        tmr_start = 1'b1;
                    end
                end
            end
            ST_WAIT_SYNC: begin
                seen_nxt = seen_upd;
                tmr_en   = 1'b1;
                // Last lane arriving on the expiry cycle still counts as aligned.
                if (&seen_upd) begin
                    state_nxt = ST_ALIGNED;
                    tmr_clr   = 1'b1;
                end else if (tmr_expired) begin
                    state_nxt    = ST_ERROR;
                    seen_nxt     = '0;
                    skew_err_nxt = 1'b1;
                    tmr_clr      = 1'b1;
                end
            end
            ST_ALIGNED: begin
                tmr_clr = 1'b1;
                if (aligner_error) begin
                    state_nxt    = ST_ERROR;
                    seen_nxt     = '0;
                    skew_err_nxt = 1'b1;
                end else if (!(|lane_hs_active)) begin
                    state_nxt = ST_IDLE;
                    seen_nxt  = '0;
                end
            end
            ST_ERROR: begin
                tmr_clr  = 1'b1;
                seen_nxt = '0;
                if (!(|lane_hs_active)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                seen_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge byte_clk) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            seen        <= '0;
            skew_err    <= 1'b0;
            align_rst_n <= 1'b0;
        end else begin
            state       <= state_nxt;
            seen        <= seen_nxt;
            skew_err    <= skew_err_nxt;
            align_rst_n <= (state_nxt == ST_WAIT_SYNC) || (state_nxt == ST_ALIGNED);
        end
    end

    assign align_done        = (state == ST_ALIGNED);
    assign state_dbg         = state;
    assign lanes_valid_gated = lanes_data_in_valid & seen;

`ifdef MIPI_ALIGN_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Counts on the same edge that raises skew_err, so err_cnt already includes the pulse it shows with.
    always_ff @(posedge byte_clk) begin
        if (!sys_rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (skew_err_nxt && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_mipi_lane_align_ctrl.sv
// Self-checking bench for mipi_lane_align_ctrl: directed vector table, skew corner sequences, then random traffic vs a timestamp model.
module tb_mipi_lane_align_ctrl;

    localparam int L  = 2;
    localparam int TO = 8;

    logic         byte_clk = 1'b0;
    logic         sys_rst_n;
    logic [L-1:0] lane_hs_active;
    logic [L-1:0] lane_sync_det;
    logic [L-1:0] lanes_data_in_valid;
    logic         aligner_error;
    logic [L-1:0] lanes_valid_gated;
    logic         align_rst_n;
    logic         align_done;
    logic         skew_err;
    logic [7:0]   err_cnt;
    logic [1:0]   state_dbg;

    always #5 byte_clk = ~byte_clk;

    mipi_lane_align_ctrl #(
        .LANES        (L),
        .SKEW_TIMEOUT (TO)
    ) dut (
        .byte_clk            (byte_clk),
        .sys_rst_n           (sys_rst_n),
        .lane_hs_active      (lane_hs_active),
        .lane_sync_det       (lane_sync_det),
        .lanes_data_in_valid (lanes_data_in_valid),
        .aligner_error       (aligner_error),
        .lanes_valid_gated   (lanes_valid_gated),
        .align_rst_n         (align_rst_n),
        .align_done          (align_done),
        .skew_err            (skew_err),
        .err_cnt             (err_cnt),
        .state_dbg           (state_dbg)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: burst phase, lanes seen, cycle stamp of first sync, error tally.
    int           m_phase = 0;
    logic [L-1:0] m_seen  = '0;
    int           m_first = 0;
    int           m_cyc   = 0;
    int           m_err   = 0;
    logic         m_pulse = 1'b0;
    logic         m_arst  = 1'b0;
    logic [L-1:0] obs_gated;

    typedef struct {
        logic         rst;
        logic [L-1:0] hs;
        logic [L-1:0] sync;
        logic [L-1:0] valid;
        logic         aerr;
        logic [L-1:0] gated;
        logic [1:0]   st;
        logic         arst;
        logic         done;
        logic         skew;
    } vec_t;

    vec_t tv[13];

    function automatic logic [31:0] exp_cnt();
`ifdef MIPI_ALIGN_ERR_CNT_EN
        return (m_err > 255) ? 255 : m_err;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic [L-1:0] hs,
                              input logic [L-1:0] sync, input logic aerr);
        m_pulse = 1'b0;
        if (!rst) begin
            m_phase = 0;
            m_seen  = '0;
            m_err   = 0;
        end else begin
            case (m_phase)
                0: if (sync != '0) begin
                    m_seen  = sync;
                    m_first = m_cyc;
                    m_phase = (sync == '1) ? 2 : 1;
                end
                1: begin
                    m_seen = m_seen | sync;
                    if (m_seen == '1) m_phase = 2;
                    else if (m_cyc - m_first == TO) begin
                        m_phase = 3; m_pulse = 1'b1; m_err++;
                    end
                end
                2: if (aerr) begin
                    m_phase = 3; m_pulse = 1'b1; m_err++;
                end else if (hs == '0) m_phase = 0;
                default: if (hs == '0) m_phase = 0;
            endcase
        end
        if (m_phase == 0 || m_phase == 3) m_seen = '0;
        m_arst = (m_phase == 1 || m_phase == 2);
        m_cyc++;
    endtask

    task automatic apply(input logic rst, input logic [L-1:0] hs, input logic [L-1:0] sync,
                         input logic [L-1:0] valid, input logic aerr);
        sys_rst_n           = rst;
        lane_hs_active      = hs;
        lane_sync_det       = sync;
        lanes_data_in_valid = valid;
        aligner_error       = aerr;
        #1;
        obs_gated = lanes_valid_gated;
        chk("gated", lanes_valid_gated, valid & m_seen);
        @(posedge byte_clk);
        model_step(rst, hs, sync, aerr);
        #1;
        chk("state", state_dbg, m_phase);
        chk("align_rst_n", align_rst_n, m_arst);
        chk("align_done", align_done, (m_phase == 2));
        chk("skew_err", skew_err, m_pulse);
        chk("err_cnt", err_cnt, exp_cnt());
        @(negedge byte_clk);
    endtask

    initial begin
        sys_rst_n = 1'b0; lane_hs_active = '0; lane_sync_det = '0;
        lanes_data_in_valid = '0; aligner_error = 1'b0;

        //            rst  hs     sync   valid  aerr  gated  st  arst done skew
        tv[0]  = '{1'b1, 2'b11, 2'b01, 2'b11, 1'b0, 2'b00, 2'd1, 1'b1, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 2'b11, 2'b00, 2'b11, 1'b0, 2'b01, 2'd1, 1'b1, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 2'b11, 2'b00, 2'b11, 1'b0, 2'b01, 2'd1, 1'b1, 1'b0, 1'b0};
        tv[3]  = '{1'b1, 2'b11, 2'b10, 2'b11, 1'b0, 2'b01, 2'd2, 1'b1, 1'b1, 1'b0};
        tv[4]  = '{1'b1, 2'b11, 2'b00, 2'b11, 1'b0, 2'b11, 2'd2, 1'b1, 1'b1, 1'b0};
        tv[5]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{1'b1, 2'b11, 2'b11, 2'b11, 1'b0, 2'b00, 2'd2, 1'b1, 1'b1, 1'b0};
        tv[7]  = '{1'b1, 2'b11, 2'b00, 2'b10, 1'b1, 2'b10, 2'd3, 1'b0, 1'b0, 1'b1};
        tv[8]  = '{1'b1, 2'b11, 2'b01, 2'b11, 1'b0, 2'b00, 2'd3, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0};
        tv[10] = '{1'b1, 2'b11, 2'b11, 2'b11, 1'b0, 2'b00, 2'd2, 1'b1, 1'b1, 1'b0};
        tv[11] = '{1'b0, 2'b11, 2'b00, 2'b11, 1'b0, 2'b11, 2'd0, 1'b0, 1'b0, 1'b0};
        tv[12] = '{1'b1, 2'b11, 2'b00, 2'b11, 1'b0, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0};

        @(negedge byte_clk);
        apply(1'b0, '0, '0, '0, 1'b0);
        apply(1'b0, '0, '0, '0, 1'b0);
        chk("reset_state", state_dbg, 0);
        chk("reset_arst", align_rst_n, 0);
        chk("reset_errcnt", err_cnt, 0);

        foreach (tv[i]) begin
            apply(tv[i].rst, tv[i].hs, tv[i].sync, tv[i].valid, tv[i].aerr);
            chk($sformatf("tv%0d_gated", i), obs_gated, tv[i].gated);
            chk($sformatf("tv%0d_state", i), state_dbg, tv[i].st);
            chk($sformatf("tv%0d_arst", i), align_rst_n, tv[i].arst);
            chk($sformatf("tv%0d_done", i), align_done, tv[i].done);
            chk($sformatf("tv%0d_skew", i), skew_err, tv[i].skew);
        end

        // Lane1 never syncs: eight cycles in WAIT_SYNC, then ERROR with one skew_err pulse.
        apply(1'b1, 2'b11, 2'b01, 2'b11, 1'b0);
        for (int i = 1; i < TO; i++) begin
            apply(1'b1, 2'b11, 2'b00, 2'b11, 1'b0);
            chk("to_waiting", state_dbg, 1);
        end
        apply(1'b1, 2'b11, 2'b00, 2'b11, 1'b0);
        chk("to_err_state", state_dbg, 3);
        chk("to_skew_pulse", skew_err, 1);
        chk("to_arst_low", align_rst_n, 0);
        apply(1'b1, 2'b11, 2'b00, 2'b11, 1'b0);
        chk("to_skew_single", skew_err, 0);
        apply(1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        chk("to_back_idle", state_dbg, 0);

        // Lane1 syncs on the very cycle the timer expires: alignment wins.
        apply(1'b1, 2'b11, 2'b01, 2'b11, 1'b0);
        for (int i = 1; i < TO; i++) apply(1'b1, 2'b11, 2'b00, 2'b11, 1'b0);
        apply(1'b1, 2'b11, 2'b10, 2'b11, 1'b0);
        chk("edge_aligned", state_dbg, 2);
        chk("edge_no_skew", skew_err, 0);
        apply(1'b1, 2'b00, 2'b00, 2'b00, 1'b0);

        for (int i = 0; i < 300; i++) begin
            apply(1'b1, 2'b11, 2'b11, 2'b11, 1'b0);
            apply(1'b1, 2'b11, 2'b00, 2'b11, 1'b1);
            apply(1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        end
`ifdef MIPI_ALIGN_ERR_CNT_EN
        chk("errcnt_saturated", err_cnt, 255);
`else
        chk("errcnt_disabled", err_cnt, 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            logic         r_rst, r_aerr;
            logic [L-1:0] r_hs, r_sync, r_valid;
            r_rst   = ($urandom_range(0, 63) != 0);
            r_hs    = ($urandom_range(0, 9) == 0) ? '0 : L'($urandom);
            for (int b = 0; b < L; b++) r_sync[b] = ($urandom_range(0, 5) == 0);
            r_valid = L'($urandom);
            r_aerr  = ($urandom_range(0, 19) == 0);
            apply(r_rst, r_hs, r_sync, r_valid, r_aerr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mipi_lane_align_ctrl.md
MIPI_LANE_ALIGN_CTRL -- requirements
Module: mipi_lane_align_ctrl

Interface
REQ-001 SHALL have parameter LANES, default 2, number of HS data lanes sequenced.
REQ-002 SHALL have parameter SKEW_TIMEOUT, default 8, max byte_clk cycles after first lane sync within which all lanes must sync.
REQ-003 SHALL have port byte_clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port sys_rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port lane_hs_active  in  LANES  per-lane HS burst active from lane receivers.
REQ-006 SHALL have port lane_sync_det  in  LANES  per-lane one-cycle pulse, sync byte found.
REQ-007 SHALL have port lanes_data_in_valid  in  LANES  per-lane byte valid from lane receivers.
REQ-008 SHALL have port aligner_error  in  1  error flag from downstream multi-lane aligner.
REQ-009 SHALL have port lanes_valid_gated  out  LANES  valid forwarded to aligner.
REQ-010 SHALL have port align_rst_n  out  1  aligner FIFO clear, active-low.
REQ-011 SHALL have port align_done  out  1  all lanes synced, burst in progress.
REQ-012 SHALL have port skew_err  out  1  one-cycle pulse on timeout or aligner error.
REQ-013 SHALL have port err_cnt  out  8  saturating error count.
REQ-014 SHALL have port state_dbg  out  2  current FSM state encoding.

Function
REQ-015 FSM SHALL have states IDLE=0, WAIT_SYNC=1, ALIGNED=2, ERROR=3.
REQ-016 seen[LANES-1:0] register SHALL record lanes that have synced in current burst; cleared in IDLE and ERROR.
REQ-017 lanes_valid_gated SHALL equal lanes_data_in_valid AND seen (combinational), so byte after a sync pulse is first forwarded.
REQ-018 align_rst_n SHALL be registered: 0 in IDLE and ERROR, 1 in WAIT_SYNC and ALIGNED.
REQ-019 IDLE: any lane_sync_det bit set -> seen<=lane_sync_det; if all bits set -> ALIGNED, else -> WAIT_SYNC with skew counter <=1.
REQ-020 WAIT_SYNC: seen<=seen|lane_sync_det; counter increments each cycle; repeated sync on a seen lane ignored.
REQ-021 WAIT_SYNC: updated seen all ones -> ALIGNED, taking priority over timeout in the same cycle.
REQ-022 WAIT_SYNC: counter==SKEW_TIMEOUT and seen incomplete -> ERROR, skew_err pulse 1 cycle.
REQ-023 ALIGNED: align_done=1; aligner_error=1 -> ERROR with skew_err pulse; else all lane_hs_active low -> IDLE.
REQ-024 ERROR: stays until all lane_hs_active low, then -> IDLE; sync pulses ignored.
REQ-025 err_cnt SHALL increment on every skew_err pulse, saturating at 255, never wrapping.
REQ-026 Skew counter width SHALL be clog2(SKEW_TIMEOUT+1); no wrap possible.

Reset
REQ-027 sys_rst_n low at a rising edge SHALL force IDLE, seen=0, counter=0, align_rst_n=0, align_done=0, skew_err=0, err_cnt=0, state_dbg=0, regardless of state (mid-burst included).
REQ-028 lanes_valid_gated SHALL be 0 during and after reset until a sync is recorded.

Configuration
REQ-029 With macro MIPI_ALIGN_ERR_CNT_EN defined, err_cnt SHALL be implemented per REQ-025.
REQ-030 Without MIPI_ALIGN_ERR_CNT_EN, err_cnt SHALL be tied to 0 and no counter registers synthesized; skew_err unaffected.

Structure
REQ-031 Shared package mipi_dsi_pkg SHALL hold FSM state enum/encoding and default LANES and SKEW_TIMEOUT constants.
REQ-032 Skew counter SHALL be sub-module mipi_skew_timer (clear, enable, expired flag at SKEW_TIMEOUT).

Verification
REQ-033 LANES=2: sync lane0 cycle 0, lane1 cycle 3 -> ALIGNED at cycle 4, align_rst_n=1 from cycle 1, lane1 valid gated until cycle 4.
REQ-034 Both syncs same cycle in IDLE -> ALIGNED next edge, no WAIT_SYNC, skew_err=0.
REQ-035 Sync lane0 only, SKEW_TIMEOUT=8 -> ERROR after 8 cycles in WAIT_SYNC, skew_err one pulse, err_cnt=1, align_rst_n=0.
REQ-036 Lane1 sync in same cycle counter reaches 8 -> ALIGNED, not ERROR.
REQ-037 ALIGNED, aligner_error=1 -> ERROR, skew_err pulse; hs_active all low -> IDLE; 300 forced errors -> err_cnt=255 (macro on), 0 (macro off).
REQ-038 sys_rst_n low 1 cycle during ALIGNED -> all outputs at reset values next edge; later sync restarts normally.
